// File: rtl/id_ex_pipeline_register_if.sv
// id_ex_pipeline_register_if: ID/EX boundary bundle
// master: ID-side driver (hazard/flush controls, decoded *_ID fields); sees *_EX, Stall_Out_ID, Bubble_Count
// slave: pipeline register; consumes *_ID fields, produces registered *_EX fields, hold request and bubble count
interface id_ex_pipeline_register_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
);
  logic Stall_EX, Flush_ID, Valid_ID;
  logic [DATA_WIDTH-1:0] PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_Instruction_ID;
  logic [REG_ADDR_WIDTH-1:0] Rs_ID, Rt_ID, Rd_ID;
  logic RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, Branch_ID, ALUSrc_ID, RegDst_ID;
  logic [1:0] ALUOp_ID;
  logic Valid_EX;
  logic [DATA_WIDTH-1:0] PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX;
  logic [REG_ADDR_WIDTH-1:0] Rs_EX, Rt_EX, Rd_EX;
  logic RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ALUSrc_EX, RegDst_EX;
  logic [1:0] ALUOp_EX;
  logic Stall_Out_ID;
  logic [COUNT_WIDTH-1:0] Bubble_Count;
  modport master (
    output Stall_EX, Flush_ID, Valid_ID, PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID,
           Sign_Extend_Instruction_ID, Rs_ID, Rt_ID, Rd_ID, RegWrite_ID, MemtoReg_ID, MemRead_ID,
           MemWrite_ID, Branch_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID,
    input  Valid_EX, PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX,
           Rs_EX, Rt_EX, Rd_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
           ALUSrc_EX, RegDst_EX, ALUOp_EX, Stall_Out_ID, Bubble_Count
  );
  modport slave (
    input  Stall_EX, Flush_ID, Valid_ID, PC_Plus_4_ID, Read_Data_1_ID, Read_Data_2_ID,
           Sign_Extend_Instruction_ID, Rs_ID, Rt_ID, Rd_ID, RegWrite_ID, MemtoReg_ID, MemRead_ID,
           MemWrite_ID, Branch_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID,
    output Valid_EX, PC_Plus_4_EX, Read_Data_1_EX, Read_Data_2_EX, Sign_Extend_Instruction_EX,
           Rs_EX, Rt_EX, Rd_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
           ALUSrc_EX, RegDst_EX, ALUOp_EX, Stall_Out_ID, Bubble_Count
  );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: MIPS32 ID/EX pipeline register with load-use detection, bubble insertion and bubble counter
// Clk, Reset (async, active-high); bus: id_ex_pipeline_register_if.slave carrying *_ID inputs,
// Stall_EX/Flush_ID controls, registered *_EX outputs, Stall_Out_ID hold request and Bubble_Count
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH = 16
) (
  input logic Clk,
  input logic Reset,
  id_ex_pipeline_register_if.slave bus
);
  logic load_use, bubble, keep;
  // a load in EX whose destination feeds the ID instruction; $0 is never a real dependency
  assign load_use = bus.Valid_ID & bus.Valid_EX & bus.MemRead_EX & (|bus.Rt_EX) &
                    ((bus.Rt_EX == bus.Rs_ID) | (bus.Rt_EX == bus.Rt_ID));
  assign bubble = bus.Flush_ID | load_use;
  assign keep = ~bubble & bus.Valid_ID;
  // a flushed instruction is discarded, so holding ID for it is pointless
  assign bus.Stall_Out_ID = bus.Stall_EX | (load_use & ~bus.Flush_ID);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      bus.Valid_EX <= 1'b0;
      bus.PC_Plus_4_EX <= DATA_WIDTH'(0);
      bus.Read_Data_1_EX <= DATA_WIDTH'(0);
      bus.Read_Data_2_EX <= DATA_WIDTH'(0);
      bus.Sign_Extend_Instruction_EX <= DATA_WIDTH'(0);
      bus.Rs_EX <= REG_ADDR_WIDTH'(0);
      bus.Rt_EX <= REG_ADDR_WIDTH'(0);
      bus.Rd_EX <= REG_ADDR_WIDTH'(0);
      bus.RegWrite_EX <= 1'b0;
      bus.MemtoReg_EX <= 1'b0;
      bus.MemRead_EX <= 1'b0;
      bus.MemWrite_EX <= 1'b0;
      bus.Branch_EX <= 1'b0;
      bus.ALUSrc_EX <= 1'b0;
      bus.RegDst_EX <= 1'b0;
      bus.ALUOp_EX <= 2'b00;
      bus.Bubble_Count <= COUNT_WIDTH'(0);
    end else if (!bus.Stall_EX) begin
      bus.Valid_EX <= keep;
      bus.PC_Plus_4_EX <= bubble ? DATA_WIDTH'(0) : bus.PC_Plus_4_ID;
      bus.Read_Data_1_EX <= bubble ? DATA_WIDTH'(0) : bus.Read_Data_1_ID;
      bus.Read_Data_2_EX <= bubble ? DATA_WIDTH'(0) : bus.Read_Data_2_ID;
      bus.Sign_Extend_Instruction_EX <= bubble ? DATA_WIDTH'(0) : bus.Sign_Extend_Instruction_ID;
      bus.Rs_EX <= bubble ? REG_ADDR_WIDTH'(0) : bus.Rs_ID;
      bus.Rt_EX <= bubble ? REG_ADDR_WIDTH'(0) : bus.Rt_ID;
      bus.Rd_EX <= bubble ? REG_ADDR_WIDTH'(0) : bus.Rd_ID;
      bus.RegWrite_EX <= keep & bus.RegWrite_ID;
      bus.MemtoReg_EX <= keep & bus.MemtoReg_ID;
      bus.MemRead_EX <= keep & bus.MemRead_ID;
      bus.MemWrite_EX <= keep & bus.MemWrite_ID;
      bus.Branch_EX <= keep & bus.Branch_ID;
      bus.ALUSrc_EX <= keep & bus.ALUSrc_ID;
      bus.RegDst_EX <= keep & bus.RegDst_ID;
      bus.ALUOp_EX <= keep ? bus.ALUOp_ID : 2'b00;
      // saturating: the increment vanishes once the counter is all ones
      bus.Bubble_Count <= bus.Bubble_Count + COUNT_WIDTH'(bubble & ~&bus.Bubble_Count);
    end
endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// tb_id_ex_pipeline_register: directed self-checking bench for id_ex_pipeline_register
module tb_id_ex_pipeline_register;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;
  int exp_bub = 0;
  always #5 Clk = ~Clk;
  id_ex_pipeline_register_if b();
  id_ex_pipeline_register_if #(.COUNT_WIDTH(2)) s();
  id_ex_pipeline_register dut (.Clk(Clk), .Reset(Reset), .bus(b.slave));
  id_ex_pipeline_register #(.COUNT_WIDTH(2)) dut_sat (.Clk(Clk), .Reset(Reset), .bus(s.slave));
  assign s.Stall_EX = b.Stall_EX;
  assign s.Flush_ID = b.Flush_ID;
  assign s.Valid_ID = b.Valid_ID;
  assign s.PC_Plus_4_ID = b.PC_Plus_4_ID;
  assign s.Read_Data_1_ID = b.Read_Data_1_ID;
  assign s.Read_Data_2_ID = b.Read_Data_2_ID;
  assign s.Sign_Extend_Instruction_ID = b.Sign_Extend_Instruction_ID;
  assign s.Rs_ID = b.Rs_ID;
  assign s.Rt_ID = b.Rt_ID;
  assign s.Rd_ID = b.Rd_ID;
  assign s.RegWrite_ID = b.RegWrite_ID;
  assign s.MemtoReg_ID = b.MemtoReg_ID;
  assign s.MemRead_ID = b.MemRead_ID;
  assign s.MemWrite_ID = b.MemWrite_ID;
  assign s.Branch_ID = b.Branch_ID;
  assign s.ALUSrc_ID = b.ALUSrc_ID;
  assign s.RegDst_ID = b.RegDst_ID;
  assign s.ALUOp_ID = b.ALUOp_ID;

  task automatic clear_inputs();
    b.Stall_EX = 0; b.Flush_ID = 0; b.Valid_ID = 0;
    b.PC_Plus_4_ID = 0; b.Read_Data_1_ID = 0; b.Read_Data_2_ID = 0; b.Sign_Extend_Instruction_ID = 0;
    b.Rs_ID = 0; b.Rt_ID = 0; b.Rd_ID = 0;
    b.RegWrite_ID = 0; b.MemtoReg_ID = 0; b.MemRead_ID = 0; b.MemWrite_ID = 0;
    b.Branch_ID = 0; b.ALUSrc_ID = 0; b.RegDst_ID = 0; b.ALUOp_ID = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_lw(input logic [4:0] rt);
    clear_inputs();
    b.Valid_ID = 1; b.MemRead_ID = 1; b.MemtoReg_ID = 1; b.RegWrite_ID = 1; b.ALUSrc_ID = 1; b.Rt_ID = rt;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    b.Valid_ID = 1; b.RegWrite_ID = 1; b.PC_Plus_4_ID = 32'h104; b.Read_Data_1_ID = 32'hdead;
    b.Rs_ID = 1; b.Rt_ID = 2; b.Sign_Extend_Instruction_ID = 32'h7;
    tick();
    total++; if (b.Valid_EX !== 1'b1) begin bad++; $display("FAIL preload Valid_EX got %0b want 1", b.Valid_EX); end
    #2 Reset = 1;
    #1;
    total++; if (b.Valid_EX !== 1'b0) begin bad++; $display("FAIL reset Valid_EX got %0b want 0", b.Valid_EX); end
    total++; if (b.RegWrite_EX !== 1'b0) begin bad++; $display("FAIL reset RegWrite_EX got %0b want 0", b.RegWrite_EX); end
    total++; if (b.PC_Plus_4_EX !== 32'h0) begin bad++; $display("FAIL reset PC_Plus_4_EX got %h want 0", b.PC_Plus_4_EX); end
    total++; if (b.Read_Data_1_EX !== 32'h0) begin bad++; $display("FAIL reset Read_Data_1_EX got %h want 0", b.Read_Data_1_EX); end
    total++; if (b.Sign_Extend_Instruction_EX !== 32'h0) begin bad++; $display("FAIL reset imm got %h want 0", b.Sign_Extend_Instruction_EX); end
    total++; if (b.Rs_EX !== 5'd0 || b.Rt_EX !== 5'd0) begin bad++; $display("FAIL reset Rs/Rt got %0d/%0d want 0/0", b.Rs_EX, b.Rt_EX); end
    total++; if (b.Bubble_Count !== 16'd0 || s.Bubble_Count !== 2'd0) begin bad++; $display("FAIL reset Bubble_Count got %0d/%0d want 0", b.Bubble_Count, s.Bubble_Count); end
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL reset Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
    Reset = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_normal();
    clear_inputs();
    b.Valid_ID = 1; b.RegWrite_ID = 1; b.Rs_ID = 3; b.Rt_ID = 4; b.Rd_ID = 5; b.ALUOp_ID = 2'b10;
    b.Read_Data_1_ID = 32'h12345678; b.Read_Data_2_ID = 32'h0badf00d;
    b.Sign_Extend_Instruction_ID = 32'hFFFF8000; b.PC_Plus_4_ID = 32'h00400004;
    tick();
    total++; if (b.Valid_EX !== 1'b1 || b.RegWrite_EX !== 1'b1) begin bad++; $display("FAIL normal Valid/RegWrite got %0b/%0b want 1/1", b.Valid_EX, b.RegWrite_EX); end
    total++; if (b.Rs_EX !== 5'd3 || b.Rt_EX !== 5'd4 || b.Rd_EX !== 5'd5) begin bad++; $display("FAIL normal specifiers got %0d/%0d/%0d want 3/4/5", b.Rs_EX, b.Rt_EX, b.Rd_EX); end
    total++; if (b.Read_Data_1_EX !== 32'h12345678) begin bad++; $display("FAIL normal Read_Data_1_EX got %h want 12345678", b.Read_Data_1_EX); end
    total++; if (b.Read_Data_2_EX !== 32'h0badf00d) begin bad++; $display("FAIL normal Read_Data_2_EX got %h want 0badf00d", b.Read_Data_2_EX); end
    total++; if (b.Sign_Extend_Instruction_EX !== 32'hFFFF8000) begin bad++; $display("FAIL normal imm got %h want ffff8000", b.Sign_Extend_Instruction_EX); end
    total++; if (b.PC_Plus_4_EX !== 32'h00400004) begin bad++; $display("FAIL normal PC_Plus_4_EX got %h want 00400004", b.PC_Plus_4_EX); end
    total++; if (b.ALUOp_EX !== 2'b10 || b.MemRead_EX !== 1'b0) begin bad++; $display("FAIL normal ALUOp/MemRead got %b/%b want 10/0", b.ALUOp_EX, b.MemRead_EX); end
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL normal Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
  endtask

  task automatic test_invalid();
    clear_inputs();
    b.Valid_ID = 0; b.RegWrite_ID = 1; b.MemRead_ID = 1; b.MemWrite_ID = 1; b.Branch_ID = 1;
    b.ALUOp_ID = 2'b11; b.Read_Data_1_ID = 32'haa;
    tick();
    total++; if (b.Valid_EX !== 1'b0) begin bad++; $display("FAIL invalid Valid_EX got %0b want 0", b.Valid_EX); end
    total++; if ({b.RegWrite_EX, b.MemRead_EX, b.MemWrite_EX, b.Branch_EX, b.ALUOp_EX} !== 6'b0) begin bad++; $display("FAIL invalid controls got %b want 000000", {b.RegWrite_EX, b.MemRead_EX, b.MemWrite_EX, b.Branch_EX, b.ALUOp_EX}); end
    total++; if (b.Read_Data_1_EX !== 32'haa) begin bad++; $display("FAIL invalid data got %h want aa", b.Read_Data_1_EX); end
    total++; if (b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL invalid Bubble_Count got %0d want %0d", b.Bubble_Count, exp_bub); end
  endtask

  task automatic test_load_use();
    load_lw(5'd8);
    total++; if (b.MemRead_EX !== 1'b1 || b.Rt_EX !== 5'd8) begin bad++; $display("FAIL lw load MemRead/Rt got %0b/%0d want 1/8", b.MemRead_EX, b.Rt_EX); end
    clear_inputs();
    b.Valid_ID = 1; b.RegWrite_ID = 1; b.RegDst_ID = 1; b.Rs_ID = 8; b.Rt_ID = 9; b.Rd_ID = 10; b.Read_Data_1_ID = 32'h55;
    #1;
    total++; if (b.Stall_Out_ID !== 1'b1) begin bad++; $display("FAIL load_use rs Stall_Out_ID got %0b want 1", b.Stall_Out_ID); end
    tick();
    exp_bub++;
    total++; if (b.Valid_EX !== 1'b0 || b.RegWrite_EX !== 1'b0 || b.MemRead_EX !== 1'b0 || b.RegDst_EX !== 1'b0) begin bad++; $display("FAIL bubble controls got V%0b W%0b R%0b D%0b want 0", b.Valid_EX, b.RegWrite_EX, b.MemRead_EX, b.RegDst_EX); end
    total++; if (b.Rs_EX !== 5'd0 || b.Read_Data_1_EX !== 32'h0) begin bad++; $display("FAIL bubble fields got Rs %0d data %h want 0", b.Rs_EX, b.Read_Data_1_EX); end
    total++; if (b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL bubble Bubble_Count got %0d want %0d", b.Bubble_Count, exp_bub); end
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL after bubble Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
    tick();
    total++; if (b.Valid_EX !== 1'b1 || b.Rs_EX !== 5'd8 || b.Rd_EX !== 5'd10 || b.RegDst_EX !== 1'b1) begin bad++; $display("FAIL advance got V%0b Rs %0d Rd %0d D%0b want 1/8/10/1", b.Valid_EX, b.Rs_EX, b.Rd_EX, b.RegDst_EX); end
    total++; if (b.Read_Data_1_EX !== 32'h55 || b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL advance data %h count %0d want 55/%0d", b.Read_Data_1_EX, b.Bubble_Count, exp_bub); end
    load_lw(5'd6);
    clear_inputs();
    b.Valid_ID = 1; b.Rs_ID = 1; b.Rt_ID = 6;
    #1;
    total++; if (b.Stall_Out_ID !== 1'b1) begin bad++; $display("FAIL load_use rt Stall_Out_ID got %0b want 1", b.Stall_Out_ID); end
    tick();
    exp_bub++;
    total++; if (b.Valid_EX !== 1'b0 || b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL rt bubble got V%0b count %0d want 0/%0d", b.Valid_EX, b.Bubble_Count, exp_bub); end
    tick();
    total++; if (b.Valid_EX !== 1'b1 || b.Rt_EX !== 5'd6) begin bad++; $display("FAIL rt advance got V%0b Rt %0d want 1/6", b.Valid_EX, b.Rt_EX); end
  endtask

  task automatic test_zero_invalid();
    load_lw(5'd0);
    clear_inputs();
    b.Valid_ID = 1; b.Rs_ID = 0; b.Rt_ID = 0;
    #1;
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL zero reg Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
    tick();
    total++; if (b.Valid_EX !== 1'b1 || b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL zero reg got V%0b count %0d want 1/%0d", b.Valid_EX, b.Bubble_Count, exp_bub); end
    load_lw(5'd8);
    clear_inputs();
    b.Valid_ID = 0; b.Rs_ID = 8;
    #1;
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL invalid hazard Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
    tick();
    total++; if (b.Valid_EX !== 1'b0 || b.Rs_EX !== 5'd8 || b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL invalid hazard got V%0b Rs %0d count %0d want 0/8/%0d", b.Valid_EX, b.Rs_EX, b.Bubble_Count, exp_bub); end
  endtask

  task automatic test_flush_hazard();
    load_lw(5'd8);
    clear_inputs();
    b.Valid_ID = 1; b.RegWrite_ID = 1; b.Rs_ID = 8; b.Flush_ID = 1;
    #1;
    total++; if (b.Stall_Out_ID !== 1'b0) begin bad++; $display("FAIL flush hazard Stall_Out_ID got %0b want 0", b.Stall_Out_ID); end
    tick();
    exp_bub++;
    total++; if (b.Valid_EX !== 1'b0 || b.RegWrite_EX !== 1'b0 || b.Rs_EX !== 5'd0) begin bad++; $display("FAIL flush bubble got V%0b W%0b Rs %0d want 0/0/0", b.Valid_EX, b.RegWrite_EX, b.Rs_EX); end
    total++; if (b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL flush Bubble_Count got %0d want %0d", b.Bubble_Count, exp_bub); end
    b.Flush_ID = 0;
  endtask

  task automatic test_stall();
    clear_inputs();
    b.Valid_ID = 1; b.RegWrite_ID = 1; b.PC_Plus_4_ID = 32'h100; b.Read_Data_1_ID = 32'h77; b.Rd_ID = 3; b.ALUOp_ID = 2'b01;
    tick();
    b.Stall_EX = 1;
    for (int i = 0; i < 3; i++) begin
      b.PC_Plus_4_ID = 32'h200 + 32'(i); b.Read_Data_1_ID = 32'(i); b.Valid_ID = i[0]; b.Flush_ID = (i == 1); b.Rd_ID = 5'(i + 20);
      #1;
      total++; if (b.Stall_Out_ID !== 1'b1) begin bad++; $display("FAIL stall %0d Stall_Out_ID got %0b want 1", i, b.Stall_Out_ID); end
      tick();
      total++; if (b.PC_Plus_4_EX !== 32'h100 || b.Read_Data_1_EX !== 32'h77 || b.Rd_EX !== 5'd3) begin bad++; $display("FAIL stall %0d hold got PC %h data %h Rd %0d want 100/77/3", i, b.PC_Plus_4_EX, b.Read_Data_1_EX, b.Rd_EX); end
      total++; if (b.Valid_EX !== 1'b1 || b.RegWrite_EX !== 1'b1 || b.ALUOp_EX !== 2'b01 || b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL stall %0d ctl got V%0b W%0b op %b count %0d want 1/1/01/%0d", i, b.Valid_EX, b.RegWrite_EX, b.ALUOp_EX, b.Bubble_Count, exp_bub); end
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs();
    b.Flush_ID = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_bub++;
      total++; if (b.Bubble_Count !== 16'(exp_bub)) begin bad++; $display("FAIL flush %0d Bubble_Count got %0d want %0d", i, b.Bubble_Count, exp_bub); end
    end
    total++; if (s.Bubble_Count !== 2'd3) begin bad++; $display("FAIL saturation Bubble_Count got %0d want 3", s.Bubble_Count); end
    b.Flush_ID = 0;
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    b.Valid_ID = 1; b.PC_Plus_4_ID = 32'h300;
    tick();
    b.Stall_EX = 1;
    tick();
    #2 Reset = 1;
    #1;
    exp_bub = 0;
    total++; if (b.Valid_EX !== 1'b0 || b.PC_Plus_4_EX !== 32'h0) begin bad++; $display("FAIL stall reset got V%0b PC %h want 0/0", b.Valid_EX, b.PC_Plus_4_EX); end
    total++; if (b.Bubble_Count !== 16'd0 || s.Bubble_Count !== 2'd0) begin bad++; $display("FAIL stall reset count got %0d/%0d want 0/0", b.Bubble_Count, s.Bubble_Count); end
    Reset = 0;
    b.Stall_EX = 0; b.PC_Plus_4_ID = 32'h304;
    tick();
    total++; if (b.Valid_EX !== 1'b1 || b.PC_Plus_4_EX !== 32'h304 || b.Bubble_Count !== 16'd0) begin bad++; $display("FAIL post reset load got V%0b PC %h count %0d want 1/304/0", b.Valid_EX, b.PC_Plus_4_EX, b.Bubble_Count); end
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge Clk);
    #1 Reset = 0;
    test_reset();
    test_normal();
    test_invalid();
    test_load_use();
    test_zero_invalid();
    test_flush_hazard();
    test_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
